instr_fetch_master: RTL and testbench



---
 rtl/instr_fetch_master.sv | 201 ++++++++++++++++++++
 tb/tb_instr_fetch_master.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_master.sv
// Instruction fetch master: walks a word-aligned PC, issues one req/gnt/rvalid
// memory transaction at a time and hands each returned word to decode over a
// valid/ready interface.
// Optional feature: define FETCH_TIMEOUT_EN to build the sticky fetch watchdog
// that drives err_o; without it err_o is a constant 0.
module instr_fetch_master #(
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR      = '0,
  parameter int                    TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en_i,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  output logic                  req_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  input  logic                  gnt_i,
  input  logic                  rvalid_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_ready_i,
  output logic                  err_o
);

  localparam int                    BYTES      = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAITR,
    HOLD
  } state_t;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   pc, pc_n;
  logic [ADDR_WIDTH-1:0]   addr_n;
  logic [ADDR_WIDTH-1:0]   instr_addr_n;
  logic [DATA_WIDTH-1:0]   instr_rdata_n;
  logic                    req_n;
  logic                    instr_valid_n;
  logic                    kill, kill_n;
  logic [ADDR_WIDTH-1:0]   branch_target;
  logic [ADDR_WIDTH-1:0]   seq_pc;

  // Branch targets are forced onto a word boundary; the sequential PC simply
  // wraps at the top of the address space.
  assign branch_target = branch_addr_i & ~ALIGN_MASK;
  assign seq_pc        = addr_o + STEP;

  // State and every output register; reset lands on the boot address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= BOOT_ADDR;
      req_o         <= 1'b0;
      addr_o        <= BOOT_ADDR;
      instr_valid_o <= 1'b0;
      instr_rdata_o <= '0;
      instr_addr_o  <= BOOT_ADDR;
      kill          <= 1'b0;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      req_o         <= req_n;
      addr_o        <= addr_n;
      instr_valid_o <= instr_valid_n;
      instr_rdata_o <= instr_rdata_n;
      instr_addr_o  <= instr_addr_n;
      kill          <= kill_n;
    end
  end

  // Next-state logic: a branch always beats a same-cycle handshake, and a
  // killed response is consumed but never shown to decode.
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    req_n         = req_o;
    addr_n        = addr_o;
    instr_valid_n = instr_valid_o;
    instr_rdata_n = instr_rdata_o;
    instr_addr_n  = instr_addr_o;
    kill_n        = kill;

    case (state)
      IDLE: begin
        if (branch_i) begin
          pc_n = branch_target;
        end
        if (fetch_en_i) begin
          state_n = REQ;
          req_n   = 1'b1;
          addr_n  = branch_i ? branch_target : pc;
        end
      end

      REQ: begin
        if (branch_i) begin
          pc_n   = branch_target;
          kill_n = 1'b1;
        end
        if (gnt_i) begin
          req_n   = 1'b0;
          state_n = WAITR;
        end
      end

      WAITR: begin
        if (branch_i) begin
          pc_n   = branch_target;
          kill_n = 1'b1;
        end
        if (rvalid_i) begin
          if (kill || branch_i) begin
            kill_n = branch_i;
            if (fetch_en_i) begin
              state_n = REQ;
              req_n   = 1'b1;
              addr_n  = pc_n;
            end else begin
              state_n = IDLE;
            end
          end else begin
            instr_valid_n = 1'b1;
            instr_rdata_n = rdata_i;
            instr_addr_n  = addr_o;
            pc_n          = seq_pc;
            state_n       = HOLD;
          end
        end
      end

      HOLD: begin
        if (branch_i || instr_ready_i) begin
          instr_valid_n = 1'b0;
          if (branch_i) begin
            pc_n = branch_target;
          end
          if (fetch_en_i) begin
            state_n = REQ;
            req_n   = 1'b1;
            addr_n  = pc_n;
          end else begin
            state_n = IDLE;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int                 CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]   LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wd_cnt, wd_cnt_n;
  logic             err_q, err_n;

  // Watchdog: restart on every entry to REQ, count while a transaction is
  // open, saturate at the limit; the error flag is sticky until reset.
  always_comb begin
    wd_cnt_n = wd_cnt;
    err_n    = err_q;
    if (state_n == REQ && state != REQ) begin
      wd_cnt_n = '0;
    end else if ((state == REQ || state == WAITR) && wd_cnt != LIMIT) begin
      wd_cnt_n = wd_cnt + CNT_W'(1);
    end
    if (wd_cnt_n == LIMIT) begin
      err_n = 1'b1;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      wd_cnt <= wd_cnt_n;
      err_q  <= err_n;
    end
  end

  assign err_o = err_q;
`else
  // Without the watchdog there is nothing to report; a non-positive limit
  // would be meaningless anyway, so this folds to a constant 0.
  assign err_o = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_instr_fetch_master.sv
// Bench for instr_fetch_master: a randomized-latency instruction memory, a
// transaction-level model of the expected instruction stream, directed
// scenarios and a random phase. Define FETCH_TIMEOUT_EN to add the watchdog test.
module tb_instr_fetch_master;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_en;
  logic          branch;
  logic [AW-1:0] branch_addr;
  logic          req_o;
  logic [AW-1:0] addr_o;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          instr_valid_o;
  logic [DW-1:0] instr_rdata_o;
  logic [AW-1:0] instr_addr_o;
  logic          ready;
  logic          err_o;

  always #5 clk = ~clk;

  instr_fetch_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .BOOT_ADDR     (8'h00),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en_i   (fetch_en),
    .branch_i     (branch),
    .branch_addr_i(branch_addr),
    .req_o        (req_o),
    .addr_o       (addr_o),
    .gnt_i        (gnt),
    .rvalid_i     (rvalid),
    .rdata_i      (rdata),
    .instr_valid_o(instr_valid_o),
    .instr_rdata_o(instr_rdata_o),
    .instr_addr_o (instr_addr_o),
    .instr_ready_i(ready),
    .err_o        (err_o)
  );

  logic [DW-1:0] mem [64];

  int checks = 0;
  int fails  = 0;

  // Memory-side knobs set by the directed scenarios.
  logic gnt_block  = 1'b0;
  logic long_delay = 1'b0;

  // Model state: which address decode must see next.
  logic [AW-1:0] exp_addr = 8'h00;
  logic          cur_valid = 1'b0;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_data;
  int            present_count = 0;
  logic          bad_seen = 1'b0;

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return {a[AW-1:2], 2'b00};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed 0x%0h, required 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic f, input logic b, input logic [AW-1:0] t,
                               input logic r);
    fetch_en    = f;
    branch      = b;
    branch_addr = t;
    ready       = r;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitPresent(input string tag, input int limit);
    int n;
    n = 0;
    while (!instr_valid_o && n < limit) begin
      nextCycle();
      n++;
    end
    checkOutput(tag, instr_valid_o, 1'b1);
  endtask

  // Instruction memory: random grant wait, random (or long) response delay,
  // rvalid held high until the next request appears.
  initial begin : responder
    logic          pending;
    int            resp_cnt;
    logic [AW-1:0] resp_addr;
    int            wait_cnt;
    logic          req_seen;
    logic [AW-1:0] addr_seen;
    logic          rst_edge;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    pending = 1'b0; resp_cnt = 0; resp_addr = '0; wait_cnt = 0;
    req_seen = 1'b0; addr_seen = '0;
    forever begin
      @(posedge clk);
      rst_edge = rst;
      #1;
      if (rst_edge) begin
        gnt = 1'b0; rvalid = 1'b0; pending = 1'b0; wait_cnt = 0;
      end else begin
        if (gnt && req_seen) begin
          gnt       = 1'b0;
          pending   = 1'b1;
          resp_addr = addr_seen;
          resp_cnt  = long_delay ? 8 : int'($urandom_range(0, 3));
          wait_cnt  = 0;
        end
        if (pending) begin
          if (resp_cnt == 0) begin
            rvalid  = 1'b1;
            rdata   = mem[resp_addr[AW-1:2]];
            pending = 1'b0;
          end else begin
            resp_cnt--;
          end
        end
        if (req_o && rvalid) rvalid = 1'b0;
        if (req_o && !gnt && !pending && !gnt_block) begin
          if (wait_cnt >= 3 || $urandom_range(0, 2) == 0) gnt = 1'b1;
          else wait_cnt++;
        end
      end
      req_seen  = req_o;
      addr_seen = addr_o;
    end
  end

  // Monitor on the falling edge: checks every newly presented instruction
  // against the model, holding rules on both interfaces, then advances the
  // model by what the coming rising edge will do.
  initial begin : monitor
    logic          prev_pend;
    logic [AW-1:0] prev_addr;
    prev_pend = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_addr  = 8'h00;
        cur_valid = 1'b0;
        prev_pend = 1'b0;
      end else begin
        if (prev_pend) checkOutput("req_held", {req_o, addr_o}, {1'b1, prev_addr});
        if (instr_valid_o) begin
          checkOutput("req_during_hold", req_o, 1'b0);
          if (!cur_valid) begin
            checkOutput("present_addr", instr_addr_o, exp_addr);
            checkOutput("present_data", instr_rdata_o, mem[exp_addr[AW-1:2]]);
            cur_valid = 1'b1;
            cur_addr  = instr_addr_o;
            cur_data  = instr_rdata_o;
            present_count++;
            if (instr_rdata_o == 32'h11111111) bad_seen = 1'b1;
          end else begin
            checkOutput("hold_stable", {instr_addr_o, instr_rdata_o}, {cur_addr, cur_data});
          end
        end else if (cur_valid) begin
          checkOutput("valid_dropped", instr_valid_o, 1'b1);
        end
        prev_pend = req_o && !gnt;
        prev_addr = addr_o;
        if (branch) begin
          exp_addr  = align(branch_addr);
          cur_valid = 1'b0;
        end else if (instr_valid_o && ready) begin
          exp_addr  = exp_addr + 8'd4;
          cur_valid = 1'b0;
        end
      end
    end
  end

  initial begin : main
    int n;
    int base;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0]  = 32'h00D00113;
    mem[1]  = 32'h00900093;
    mem[2]  = 32'h11111111;
    mem[32] = 32'hF81FF06F;

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (3) nextCycle();
    @(negedge clk);
    checkOutput("rst_req", req_o, 1'b0);
    checkOutput("rst_addr", addr_o, 8'h00);
    checkOutput("rst_valid", instr_valid_o, 1'b0);
    checkOutput("rst_rdata", instr_rdata_o, 32'h0);
    checkOutput("rst_iaddr", instr_addr_o, 8'h00);
    checkOutput("rst_err", err_o, 1'b0);
    nextCycle();
    rst = 1'b0;

    // First fetch, then decode stalls for 20 cycles.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    waitPresent("first_present", 50);
    checkOutput("first_addr", instr_addr_o, 8'h00);
    checkOutput("first_data", instr_rdata_o, 32'h00D00113);
    for (int i = 0; i < 20; i++) begin
      nextCycle();
      @(negedge clk);
      checkOutput("stall_valid", instr_valid_o, 1'b1);
      checkOutput("stall_addr", instr_addr_o, 8'h00);
      checkOutput("stall_req", req_o, 1'b0);
    end
    nextCycle();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    nextCycle();
    checkOutput("accept_req", req_o, 1'b1);
    checkOutput("accept_addr", addr_o, 8'h04);
    checkOutput("accept_valid", instr_valid_o, 1'b0);
    waitPresent("second_present", 50);
    checkOutput("second_addr", instr_addr_o, 8'h04);
    checkOutput("second_data", instr_rdata_o, 32'h00900093);

    // Branch while waiting for the response to 0x08.
    long_delay = 1'b1;
    bad_seen   = 1'b0;
    n = 0;
    while (!(req_o == 1'b0 && !instr_valid_o && addr_o == 8'h08) && n < 40) begin
      nextCycle();
      n++;
    end
    checkOutput("reach_waitr_08", (req_o == 1'b0 && !instr_valid_o && addr_o == 8'h08), 1'b1);
    applyStimulus(1'b1, 1'b1, 8'h82, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    long_delay = 1'b0;
    waitPresent("branch_present", 80);
    checkOutput("branch_addr", instr_addr_o, 8'h80);
    checkOutput("branch_data", instr_rdata_o, 32'hF81FF06F);
    checkOutput("killed_hidden", bad_seen, 1'b0);

    // Wrap from the top word back to 0x00.
    applyStimulus(1'b1, 1'b1, 8'hFC, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    n = 0;
    while (!(instr_valid_o && instr_addr_o == 8'hFC) && n < 50) begin
      nextCycle();
      n++;
    end
    checkOutput("wrap_fc_present", (instr_valid_o && instr_addr_o == 8'hFC), 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("wrap_req", req_o, 1'b1);
    checkOutput("wrap_addr", addr_o, 8'h00);
    waitPresent("wrap_present", 50);
    checkOutput("wrap_iaddr", instr_addr_o, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);

    // Drop fetch enable while a request is pending.
    n = 0;
    while (!req_o && n < 20) begin
      nextCycle();
      n++;
    end
    checkOutput("drop_in_req", req_o, 1'b1);
    base = present_count;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    repeat (20) nextCycle();
    for (int i = 0; i < 20; i++) begin
      nextCycle();
      checkOutput("drop_idle_req", req_o, 1'b0);
    end
    checkOutput("drop_count", present_count - base, 1);
    checkOutput("drop_valid", instr_valid_o, 1'b0);

    // Reset in the middle of a transaction.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    n = 0;
    while (!req_o && n < 20) begin nextCycle(); n++; end
    while (req_o && n < 40) begin nextCycle(); n++; end
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    checkOutput("midrst_req", req_o, 1'b0);
    checkOutput("midrst_valid", instr_valid_o, 1'b0);
    checkOutput("midrst_addr", addr_o, 8'h00);
    checkOutput("midrst_iaddr", instr_addr_o, 8'h00);
    waitPresent("midrst_present", 50);
    checkOutput("midrst_first", instr_addr_o, 8'h00);

    // Random traffic: stalls, branches, fetch-enable gaps, memory latency.
    base = present_count;
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 19) != 0, $urandom_range(0, 24) == 0,
                    8'($urandom), $urandom_range(0, 9) < 7);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    repeat (30) nextCycle();
    checkOutput("random_progress", (present_count - base) > 100, 1'b1);
    checkOutput("err_quiet", err_o, 1'b0);

`ifdef FETCH_TIMEOUT_EN
    begin
      int req_k;
      int err_k;
      rst = 1'b1;
      gnt_block = 1'b1;
      nextCycle();
      nextCycle();
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
      n = 0; req_k = -1; err_k = -1;
      while (n < 100 && err_k < 0) begin
        nextCycle();
        n++;
        if (req_k < 0 && req_o) req_k = n;
        if (err_k < 0 && err_o) err_k = n;
      end
      checkOutput("timeout_delay", err_k - req_k, 16);
      repeat (5) nextCycle();
      checkOutput("timeout_sticky", err_o, 1'b1);
      checkOutput("timeout_req", req_o, 1'b1);
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
      gnt_block = 1'b0;
      checkOutput("timeout_rst_err", err_o, 1'b0);
      checkOutput("timeout_rst_req", req_o, 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
